ball_sprite_renderer: RTL

Pixel-stage consumer of the hvsync_generator outputs (hsync, vsync, display_on, hpos, vpos). It draws a square ball that bounces, a 1-pixel border and a background colour. It emits registered RGB together with sync and DE signals delayed so all three stay aligned. Ball position updates once per frame, at the vsync leading edge, so the image never tears.

---
 rtl/ball_sprite_renderer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ball_sprite_renderer.sv
// Bouncing square ball over a bordered background, fed by hvsync_generator timing.
// RGB, DE and sync leave through a matched two-stage pipeline; the ball moves once per frame at vsync.
//
// state  | meaning
// IDLE   | waiting for the vsync leading edge
// MOVE_X | step ball_x, bounce off the left/right walls
// MOVE_Y | step ball_y, bounce off the top/bottom walls
// DONE   | raise bounce if either axis hit a wall
module ball_sprite_renderer #(
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          BALL_SIZE    = 16,
    parameter int          INIT_X       = 128,
    parameter int          INIT_Y       = 96,
    parameter int          SPEED        = 2,
    parameter logic        VS_POL       = 1'b0,
    parameter logic [23:0] BG_COLOR     = 24'h000080,
    parameter logic [23:0] BORDER_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BALL_COLOR   = 24'hFFFF00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        display_on,
    input  logic [11:0] hpos,
    input  logic [11:0] vpos,
    input  logic        pause,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        de_out,
    output logic [23:0] rgb,
    output logic [11:0] ball_x,
    output logic [11:0] ball_y,
    output logic [15:0] frame_cnt,
    output logic        bounce
);

    typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, DONE} state_t;

    localparam logic [12:0] SIZE13  = 13'(BALL_SIZE);
    localparam logic [12:0] SPEED13 = 13'(SPEED);
    localparam logic [12:0] X_MAX13 = 13'(H_ACTIVE - BALL_SIZE);
    localparam logic [12:0] Y_MAX13 = 13'(V_ACTIVE - BALL_SIZE);
    localparam logic [11:0] H_LAST  = 12'(H_ACTIVE - 1);
    localparam logic [11:0] V_LAST  = 12'(V_ACTIVE - 1);

    state_t      state_q, state_d;
    logic        in_ball_q, in_ball_d;
    logic        on_border_q, on_border_d;
    logic        de1_q, hs1_q, vs1_q;
    logic        de2_q, hs2_q, vs2_q;
    logic [23:0] rgb_q, rgb_d;
    logic [11:0] ball_x_q, ball_x_d;
    logic [11:0] ball_y_q, ball_y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;
    logic        hit_x_q, hit_x_d;
    logic        hit_y_q, hit_y_d;
    logic        bounce_q, bounce_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        vs_prev_q;
    logic        vs_start;
    logic [12:0] hpos13, vpos13, bx13, by13;
    logic [13:0] step_x, step_y;

    // Returns {hit, new_dir, new_pos}; dir 0 = increasing, 1 = decreasing.
    function automatic logic [13:0] axis_step(input logic [11:0] pos, input logic neg,
                                              input logic [12:0] pos_max);
        logic [12:0] pos13;
        logic [12:0] moved;
        pos13 = {1'b0, pos};
        if (!neg) begin
            moved = pos13 + SPEED13;
            if (moved >= pos_max) axis_step = {1'b1, 1'b1, pos_max[11:0]};
            else                  axis_step = {1'b0, 1'b0, moved[11:0]};
        end else begin
            moved = pos13 - SPEED13;
            if (pos13 <= SPEED13) axis_step = {1'b1, 1'b0, 12'd0};
            else                  axis_step = {1'b0, 1'b1, moved[11:0]};
        end
    endfunction

    assign vs_start = (vsync_in == VS_POL) && (vs_prev_q != VS_POL);

    always_comb begin
        hpos13 = {1'b0, hpos};
        vpos13 = {1'b0, vpos};
        bx13   = {1'b0, ball_x_q};
        by13   = {1'b0, ball_y_q};
        in_ball_d = (hpos13 >= bx13) && (hpos13 < bx13 + SIZE13) &&
                    (vpos13 >= by13) && (vpos13 < by13 + SIZE13);
        on_border_d = (hpos == 12'd0) || (hpos == H_LAST) ||
                      (vpos == 12'd0) || (vpos == V_LAST);
    end

    always_comb begin
        rgb_d = 24'h000000;
        if (de1_q) begin
            if (in_ball_q)        rgb_d = BALL_COLOR;
            else if (on_border_q) rgb_d = BORDER_COLOR;
            else                  rgb_d = BG_COLOR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vs_start) state_d = MOVE_X;
            MOVE_X:  state_d = MOVE_Y;
            MOVE_Y:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        hit_x_d     = hit_x_q;
        hit_y_d     = hit_y_q;
        bounce_d    = 1'b0;
        frame_cnt_d = frame_cnt_q;
        step_x      = axis_step(ball_x_q, dir_x_q, X_MAX13);
        step_y      = axis_step(ball_y_q, dir_y_q, Y_MAX13);
        case (state_q)
            IDLE: if (vs_start) frame_cnt_d = frame_cnt_q + 16'd1;
            MOVE_X: if (!pause) begin
                hit_x_d  = step_x[13];
                dir_x_d  = step_x[12];
                ball_x_d = step_x[11:0];
            end
            MOVE_Y: if (!pause) begin
                hit_y_d  = step_y[13];
                dir_y_d  = step_y[12];
                ball_y_d = step_y[11:0];
            end
            DONE: begin
                bounce_d = hit_x_q | hit_y_q;
                hit_x_d  = 1'b0;
                hit_y_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ball_q   <= 1'b0;
            on_border_q <= 1'b0;
            de1_q       <= 1'b0;
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
            de2_q       <= 1'b0;
            hs2_q       <= 1'b0;
            vs2_q       <= 1'b0;
            rgb_q       <= 24'h000000;
            ball_x_q    <= 12'(INIT_X);
            ball_y_q    <= 12'(INIT_Y);
            dir_x_q     <= 1'b0;
            dir_y_q     <= 1'b0;
            hit_x_q     <= 1'b0;
            hit_y_q     <= 1'b0;
            bounce_q    <= 1'b0;
            frame_cnt_q <= 16'd0;
            vs_prev_q   <= ~VS_POL;
        end else begin
            in_ball_q   <= in_ball_d;
            on_border_q <= on_border_d;
            de1_q       <= display_on;
            hs1_q       <= hsync_in;
            vs1_q       <= vsync_in;
            de2_q       <= de1_q;
            hs2_q       <= hs1_q;
            vs2_q       <= vs1_q;
            rgb_q       <= rgb_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            hit_x_q     <= hit_x_d;
            hit_y_q     <= hit_y_d;
            bounce_q    <= bounce_d;
            frame_cnt_q <= frame_cnt_d;
            vs_prev_q   <= vsync_in;
        end
    end

    assign hsync_out = hs2_q;
    assign vsync_out = vs2_q;
    assign de_out    = de2_q;
    assign rgb       = rgb_q;
    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign frame_cnt = frame_cnt_q;
    assign bounce    = bounce_q;

endmodule
